// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row strobing, column synchronisation, frame-based
// press/release debounce and a first-word-fall-through key event FIFO.
module keypad_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 4096,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4,
    localparam int CW            = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            reset,
    output logic [ROWS-1:0] row,
    input  logic [COLS-1:0] col,
    output logic            key_valid,
    output logic [CW-1:0]   key_code,
    input  logic            key_ready,
    output logic            key_held,
    output logic            overflow
);

    localparam int DW  = $clog2(SCAN_DIV);
    localparam int RW  = $clog2(ROWS);
    localparam int CCW = $clog2(COLS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NW  = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    logic [COLS-1:0] col_s1, col_s2;
    logic [DW-1:0]   div;
    logic [RW-1:0]   row_idx, row_idx_next;
    logic            sample, last_row;

    logic            row_hit;
    logic [CCW-1:0]  hit_col;
    logic [CW-1:0]   row_code;
    logic            base_any, cur_any;
    logic [CW-1:0]   base_code, cur_code;
    logic            acc_any;
    logic [CW-1:0]   acc_code;
    logic            frame_done, fd_any;
    logic [CW-1:0]   fd_code;

    state_t          state, state_n;
    logic [NW-1:0]   cnt, cnt_n;
    logic [CW-1:0]   cand, cand_n;
    logic            push;
    logic [CW-1:0]   push_code;

    logic [CW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_n;
    logic [AW:0]     count, count_n;
    logic            full, pop, wr_en, head_from_push;
    logic [CW-1:0]   head_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_s1 <= '1;
            col_s2 <= '1;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
        end
    end

    assign sample       = (div == DW'(SCAN_DIV - 1));
    assign last_row     = (row_idx == RW'(ROWS - 1));
    assign row_idx_next = last_row ? '0 : row_idx + RW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= '0;
            row_idx <= '0;
            row     <= ~ROWS'(1);
        end else if (sample) begin
            div     <= '0;
            row_idx <= row_idx_next;
            row     <= ~(ROWS'(1) << row_idx_next);
        end else begin
            div     <= div + DW'(1);
        end
    end

    // Lowest pressed column in the row currently being sampled.
    always_comb begin
        row_hit = 1'b0;
        hit_col = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (!row_hit && !col_s2[i]) begin
                row_hit = 1'b1;
                hit_col = CCW'(i);
            end
        end
    end

    assign row_code  = CW'(row_idx) * CW'(COLS) + CW'(hit_col);
    assign base_any  = (row_idx == '0) ? 1'b0 : acc_any;
    assign base_code = (row_idx == '0) ? '0 : acc_code;
    assign cur_any   = base_any | row_hit;
    assign cur_code  = base_any ? base_code : (row_hit ? row_code : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_any    <= 1'b0;
            acc_code   <= '0;
            frame_done <= 1'b0;
            fd_any     <= 1'b0;
            fd_code    <= '0;
        end else begin
            frame_done <= sample && last_row;
            if (sample) begin
                acc_any  <= cur_any;
                acc_code <= cur_code;
                if (last_row) begin
                    fd_any  <= cur_any;
                    fd_code <= cur_code;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cand_n    = cand;
        push      = 1'b0;
        push_code = cand;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (fd_any) begin
                        cand_n = fd_code;
                        cnt_n  = NW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            push      = 1'b1;
                            push_code = fd_code;
                            state_n   = HELD;
                        end else begin
                            state_n = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (!fd_any) begin
                        state_n = IDLE;
                    end else if (fd_code != cand) begin
                        cand_n = fd_code;
                        cnt_n  = NW'(1);
                    end else if (cnt == NW'(DEBOUNCE_SCANS - 1)) begin
                        push    = 1'b1;
                        state_n = HELD;
                    end else begin
                        cnt_n = cnt + NW'(1);
                    end
                end
                HELD: begin
                    if (!fd_any) begin
                        cnt_n   = NW'(1);
                        state_n = (DEBOUNCE_SCANS == 1) ? IDLE : REL_DB;
                    end
                end
                REL_DB: begin
                    if (fd_any) begin
                        state_n = HELD;
                    end else if (cnt == NW'(DEBOUNCE_SCANS - 1)) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + NW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign key_held = (state == HELD) || (state == REL_DB);

    assign key_valid = (count != '0);
    assign full      = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop       = key_valid && key_ready;
    assign wr_en     = push && (!full || pop);
    assign rd_n      = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_n = count;
        case ({wr_en, pop})
            2'b10:   count_n = count + (AW + 1)'(1);
            2'b01:   count_n = count - (AW + 1)'(1);
            default: count_n = count;
        endcase
    end

    // key_code is a register so it can hold its last value once the FIFO drains.
    assign head_from_push = (count == '0) || (pop && count == (AW + 1)'(1));
    assign head_n         = head_from_push ? push_code : mem[rd_n];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            key_code <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_n;
            count  <= count_n;
            if (count_n != '0) begin
                key_code <= head_n;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
